img_cap_seq: RTL



---
 rtl/img_cap_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/img_cap_seq.sv
// Capture sequencer: per-channel init with timeout/retry, framebuffer prefill, streaming, halt/restart.
// Optional per-channel frame watchdog in S_STREAM enabled by defining IMG_CAP_SEQ_WATCHDOG_EN.
module img_cap_seq #(
    parameter int NUM_CH         = 2,
    parameter int INIT_TIMEOUT   = 1000000,
    parameter int MAX_RETRY      = 3,
    parameter int PREFILL_FRAMES = 2,
    parameter int FRAME_TIMEOUT  = 4000000,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] init_done,
    input  logic [NUM_CH-1:0] frame_start,
    input  logic              halt,
    input  logic              restart,
    output logic [NUM_CH-1:0] init_start,
    output logic              stream_en,
    output logic              error,
    output logic [2:0]        state_o,
    output logic [1:0]        retry_cnt,
    output logic [NUM_CH-1:0] err_ch
);

    localparam int AW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int FW = (PREFILL_FRAMES > 1) ? $clog2(PREFILL_FRAMES + 1) : 1;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_INIT      = 3'd1,
        S_INIT_WAIT = 3'd2,
        S_PREFILL   = 3'd3,
        S_STREAM    = 3'd4,
        S_IDLE      = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    if (NUM_CH < 1 || NUM_CH > 8 || INIT_TIMEOUT < 2 || MAX_RETRY < 1 ||
        PREFILL_FRAMES < 1 || FRAME_TIMEOUT < 2) begin : g_bad_params
        $error("img_cap_seq: illegal parameter combination");
    end

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  timer, timer_nxt;
    logic [NUM_CH-1:0] done_latch, done_latch_nxt;
    logic [NUM_CH-1:0] done_all;
    logic [AW-1:0]     attempts, attempts_nxt;
    logic [1:0]        retry_nxt;
    logic [NUM_CH-1:0] err_ch_nxt;
    logic [FW-1:0]     cnt     [NUM_CH];
    logic [FW-1:0]     cnt_nxt [NUM_CH];
    logic              all_full;
    logic              restart_ok;

`ifdef IMG_CAP_SEQ_WATCHDOG_EN
    logic [CNT_W-1:0]  wd     [NUM_CH];
    logic [CNT_W-1:0]  wd_nxt [NUM_CH];
    logic [NUM_CH-1:0] expired;
`endif

    assign done_all   = done_latch | init_done;
    assign restart_ok = restart && (state == S_PREFILL || state == S_STREAM ||
                                    state == S_IDLE    || state == S_ERROR);

    always_comb begin
        state_nxt      = state;
        timer_nxt      = timer;
        done_latch_nxt = done_latch;
        attempts_nxt   = attempts;
        retry_nxt      = retry_cnt;
        err_ch_nxt     = err_ch;
        cnt_nxt        = cnt;
        all_full       = 1'b1;
`ifdef IMG_CAP_SEQ_WATCHDOG_EN
        wd_nxt         = wd;
        expired        = '0;
`endif
        case (state)
            S_RESET: state_nxt = S_INIT;
            S_INIT: begin
                timer_nxt      = '0;
                done_latch_nxt = '0;
                state_nxt      = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                done_latch_nxt = done_all;
                timer_nxt      = timer + 1'b1;
                if (&done_all) begin
                    state_nxt = S_PREFILL;
                    for (int unsigned i = 0; i < NUM_CH; i++) cnt_nxt[i] = '0;
                end else if (timer == CNT_W'(INIT_TIMEOUT - 1)) begin
                    attempts_nxt = attempts + 1'b1;
                    retry_nxt    = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
                    if (attempts_nxt == AW'(MAX_RETRY)) begin
                        state_nxt  = S_ERROR;
                        err_ch_nxt = ~done_all;
                    end else begin
                        state_nxt = S_INIT;
                    end
                end
            end
            S_PREFILL: begin
                // Decide on the updated counts so the state flips the cycle after the last frame.
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (frame_start[i] && cnt[i] != FW'(PREFILL_FRAMES))
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    if (cnt_nxt[i] != FW'(PREFILL_FRAMES))
                        all_full = 1'b0;
                end
                if (all_full) begin
                    state_nxt = S_STREAM;
`ifdef IMG_CAP_SEQ_WATCHDOG_EN
                    for (int unsigned i = 0; i < NUM_CH; i++) wd_nxt[i] = '0;
`endif
                end
            end
            S_STREAM: begin
                if (halt) state_nxt = S_IDLE;
`ifdef IMG_CAP_SEQ_WATCHDOG_EN
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    expired[i] = (wd[i] == CNT_W'(FRAME_TIMEOUT - 1));
                    wd_nxt[i]  = frame_start[i] ? '0 : wd[i] + 1'b1;
                end
                if (|expired) begin
                    state_nxt  = S_ERROR;
                    err_ch_nxt = expired;
                end
`endif
            end
            S_IDLE:  state_nxt = S_IDLE;
            S_ERROR: state_nxt = S_ERROR;
            default: state_nxt = S_RESET;
        endcase

        if (restart_ok) begin
            state_nxt    = S_INIT;
            attempts_nxt = '0;
            retry_nxt    = '0;
            err_ch_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_RESET;
            timer      <= '0;
            done_latch <= '0;
            attempts   <= '0;
            retry_cnt  <= '0;
            err_ch     <= '0;
            cnt        <= '{default: '0};
            init_start <= '0;
            stream_en  <= 1'b0;
            error      <= 1'b0;
`ifdef IMG_CAP_SEQ_WATCHDOG_EN
            wd         <= '{default: '0};
`endif
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            done_latch <= done_latch_nxt;
            attempts   <= attempts_nxt;
            retry_cnt  <= retry_nxt;
            err_ch     <= err_ch_nxt;
            cnt        <= cnt_nxt;
            // Registered outputs decoded from the next state so they align with state_o.
            init_start <= (state_nxt == S_INIT) ? '1 : '0;
            stream_en  <= (state_nxt == S_STREAM);
            error      <= (state_nxt == S_ERROR);
`ifdef IMG_CAP_SEQ_WATCHDOG_EN
            wd         <= wd_nxt;
`endif
        end
    end

    assign state_o = state;

endmodule
